// File: rtl/ps2_packet_rx_if.sv
// ps2_packet_rx_if: valid/ready packet handshake between the PS/2 receiver and its consumer
// Signals: packet_valid (master->slave) packet_data holds a complete packet;
//   packet_data (master->slave) first received byte in [7:0]; packet_ready (slave->master) accept.
interface ps2_packet_rx_if #(
   parameter int PACKET_BYTES = 3
) ();
   logic                      packet_valid;
   logic                      packet_ready;
   logic [8*PACKET_BYTES-1:0] packet_data;
   modport master (output packet_valid, output packet_data, input packet_ready);
   modport slave (input packet_valid, input packet_data, output packet_ready);
endinterface

// File: rtl/ps2_packet_rx.sv
// ps2_packet_rx: PS/2 device-to-host receiver assembling PACKET_BYTES-byte packets
// Ports: ck system clock; reset async active-low; ps2_clk/ps2_data raw PS/2 lines;
//   pkt (master modport) packet_valid/packet_data out, packet_ready in;
//   err_parity/err_frame/err_timeout/err_overrun one-cycle error pulses.
// Option: define PS2_PACKET_RX_ERRCNT_EN to add err_count_clr input and saturating err_count[7:0].
module ps2_packet_rx #(
   parameter int PACKET_BYTES   = 3,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 3400
) (
   input  logic ck,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   ps2_packet_rx_if.master pkt,
   output logic err_parity,
   output logic err_frame,
   output logic err_timeout,
   output logic err_overrun
`ifdef PS2_PACKET_RX_ERRCNT_EN
   ,
   input  logic       err_count_clr,
   output logic [7:0] err_count
`endif
);
   localparam int W = 8 * PACKET_BYTES;
   typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP} state_t;
   state_t st_q, st_d;
   logic [1:0] ck_sync_q, dt_sync_q;
   logic filt_q, filt_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic fall, to, busy, sd, done;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bcnt_q, bcnt_d, idx_q, idx_d;
   logic bit_q, bit_d, par_q, par_d, eval_q, eval_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [W-1:0] asm_q, asm_d, asm_w, data_q, data_d;
   logic valid_q, valid_d;
   logic perr_d, ferr_d, terr_d, oerr_d;
   assign sd = dt_sync_q[1];
   assign busy = (st_q != IDLE) || (idx_q != 3'd0);
   // Level must disagree with the filtered clock for FILTER_LEN consecutive samples to flip it.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (ck_sync_q[1] != filt_q) begin
         if (fcnt_q == 4'(FILTER_LEN - 1)) filt_d = ck_sync_q[1];
         else fcnt_d = fcnt_q + 4'd1;
      end
   end
   assign fall = filt_q & ~filt_d;
   assign to = busy && (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
   always_comb begin
      st_d = st_q;
      shift_d = shift_q;
      bcnt_d = bcnt_q;
      bit_d = bit_q;
      par_d = par_q;
      eval_d = 1'b0;
      idx_d = idx_q;
      asm_d = asm_q;
      data_d = data_q;
      valid_d = valid_q & ~pkt.packet_ready;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      terr_d = 1'b0;
      oerr_d = 1'b0;
      done = 1'b0;
      tcnt_d = fall ? '0 : busy ? tcnt_q + 16'd1 : '0;
      asm_w = asm_q;
      for (int i = 0; i < PACKET_BYTES; i++)
         if (idx_q == 3'(i)) asm_w[8*i +: 8] = shift_q;
      // Timeout takes priority over a coincident fall strobe and a pending evaluation.
      if (to) begin
         st_d = IDLE;
         idx_d = '0;
         tcnt_d = '0;
         terr_d = 1'b1;
      end else begin
         if (eval_q) begin
            if (!bit_q) begin
               ferr_d = 1'b1;
               idx_d = '0;
            end else if (!(^{shift_q, par_q})) begin
               perr_d = 1'b1;
               idx_d = '0;
            end else if (idx_q == 3'(PACKET_BYTES - 1)) begin
               idx_d = '0;
               done = 1'b1;
            end else begin
               asm_d = asm_w;
               idx_d = idx_q + 3'd1;
            end
         end
         if (done) begin
            if (!valid_q || pkt.packet_ready) begin
               data_d = asm_w;
               valid_d = 1'b1;
            end else oerr_d = 1'b1;
         end
         case (st_q)
            IDLE: if (fall) begin
               bit_d = sd;
               st_d = START_CHK;
            end
            START_CHK: begin
               ferr_d = ferr_d | bit_q;
               st_d = bit_q ? IDLE : DATA;
               bcnt_d = '0;
            end
            DATA: if (fall) begin
               shift_d = {sd, shift_q[7:1]};
               bcnt_d = bcnt_q + 3'd1;
               st_d = (bcnt_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: if (fall) begin
               par_d = sd;
               st_d = STOP;
            end
            STOP: if (fall) begin
               bit_d = sd;
               eval_d = 1'b1;
               st_d = IDLE;
            end
            default: st_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         ck_sync_q <= '1;
         dt_sync_q <= '1;
         filt_q <= 1'b1;
         fcnt_q <= '0;
         st_q <= IDLE;
         shift_q <= '0;
         bcnt_q <= '0;
         bit_q <= 1'b0;
         par_q <= 1'b0;
         eval_q <= 1'b0;
         idx_q <= '0;
         tcnt_q <= '0;
         asm_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         err_parity <= 1'b0;
         err_frame <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         ck_sync_q <= {ck_sync_q[0], ps2_clk};
         dt_sync_q <= {dt_sync_q[0], ps2_data};
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
         st_q <= st_d;
         shift_q <= shift_d;
         bcnt_q <= bcnt_d;
         bit_q <= bit_d;
         par_q <= par_d;
         eval_q <= eval_d;
         idx_q <= idx_d;
         tcnt_q <= tcnt_d;
         asm_q <= asm_d;
         data_q <= data_d;
         valid_q <= valid_d;
         err_parity <= perr_d;
         err_frame <= ferr_d;
         err_timeout <= terr_d;
         err_overrun <= oerr_d;
      end
   end
   assign pkt.packet_valid = valid_q;
   assign pkt.packet_data = data_q;
`ifdef PS2_PACKET_RX_ERRCNT_EN
   logic [7:0] ecnt_q;
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) ecnt_q <= '0;
      else if (err_count_clr) ecnt_q <= '0;
      else if ((err_parity | err_frame | err_timeout | err_overrun) && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
   end
   assign err_count = ecnt_q;
`endif
endmodule

// File: tb/tb_ps2_packet_rx.sv
// tb_ps2_packet_rx: randomized self-checking bench for ps2_packet_rx against a byte-level packet model
module tb_ps2_packet_rx;
   localparam int PB = 3;
   localparam int TO = 3400;
   logic ck = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic err_parity, err_frame, err_timeout, err_overrun;
   ps2_packet_rx_if #(.PACKET_BYTES(PB)) pkt ();
`ifdef PS2_PACKET_RX_ERRCNT_EN
   logic err_count_clr = 1'b0;
   logic [7:0] err_count;
`endif
   ps2_packet_rx #(.PACKET_BYTES(PB), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
      .ck(ck), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pkt(pkt),
      .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout), .err_overrun(err_overrun)
`ifdef PS2_PACKET_RX_ERRCNT_EN
      , .err_count_clr(err_count_clr), .err_count(err_count)
`endif
   );
   always #5 ck = ~ck;
   int cyc = 0, n_par = 0, n_frm = 0, n_to = 0, n_ovr = 0;
   logic [8*PB-1:0] acc[$];
   always @(negedge ck) begin
      cyc <= cyc + 1;
      n_par <= n_par + int'(err_parity);
      n_frm <= n_frm + int'(err_frame);
      n_to <= n_to + int'(err_timeout);
      n_ovr <= n_ovr + int'(err_overrun);
      if (pkt.packet_valid === 1'b1 && pkt.packet_ready === 1'b1) acc.push_back(pkt.packet_data);
   end
   int n_chk = 0, n_pass = 0, last_fall = 0;
   int exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovr = 0;
   logic [7:0] part[$];
   logic [8*PB-1:0] exp_pk[$];
   task automatic wait_ck(input int n);
      repeat (n) @(negedge ck);
   endtask
   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_ck(10);
      ps2_clk = 1'b0;
      last_fall = cyc;
      wait_ck(20);
      ps2_clk = 1'b1;
      wait_ck(10);
   endtask
   // Sends one frame and updates the model: a packet is the PB most recent good bytes, first byte lowest.
   task automatic tx(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic [8*PB-1:0] v;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~^d ^ bad_par);
      ps2_bit(~bad_stop);
      if (bad_stop) begin
         exp_frm++;
         part.delete();
      end else if (bad_par) begin
         exp_par++;
         part.delete();
      end else begin
         part.push_back(d);
         if (part.size() == PB) begin
            v = '0;
            for (int i = 0; i < PB; i++) v = v | ((8*PB)'(part[i]) << (8 * i));
            exp_pk.push_back(v);
            part.delete();
         end
      end
      wait_ck(5);
   endtask
   task automatic test_reset();
      reset = 1'b0;
      wait_ck(3);
      n_chk++; if (pkt.packet_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", pkt.packet_valid); else n_pass++;
      n_chk++; if (pkt.packet_data !== '0) $display("FAIL reset_data got %h exp 0", pkt.packet_data); else n_pass++;
      n_chk++; if ({err_parity, err_frame, err_timeout, err_overrun} !== 4'b0) $display("FAIL reset_err got %b exp 0000", {err_parity, err_frame, err_timeout, err_overrun}); else n_pass++;
      reset = 1'b1;
      wait_ck(5);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      #3 reset = 1'b0;
      wait_ck(3);
      #3 reset = 1'b1;
      wait_ck(50);
      n_chk++; if (n_par + n_frm + n_to + n_ovr !== 0) $display("FAIL reset_midframe_err got %0d exp 0", n_par + n_frm + n_to + n_ovr); else n_pass++;
      n_chk++; if (pkt.packet_valid !== 1'b0) $display("FAIL reset_midframe_valid got %b exp 0", pkt.packet_valid); else n_pass++;
   endtask
   task automatic test_basic();
      int s = acc.size();
      tx(8'h08, 1'b0, 1'b0);
      tx(8'h05, 1'b0, 1'b0);
      tx(8'hFB, 1'b0, 1'b0);
      wait_ck(20);
      n_chk++; if (acc.size() !== s + 1) $display("FAIL basic_count got %0d exp %0d", acc.size(), s + 1); else n_pass++;
      n_chk++; if (acc.size() <= s || acc[s] !== 24'hFB0508) $display("FAIL basic_data got %h exp fb0508", acc.size() > s ? acc[s] : 'x); else n_pass++;
      n_chk++; if (n_par + n_frm + n_to + n_ovr !== 0) $display("FAIL basic_err got %0d exp 0", n_par + n_frm + n_to + n_ovr); else n_pass++;
   endtask
   task automatic test_parity();
      tx(8'($urandom), 1'b0, 1'b0);
      tx(8'h5A, 1'b1, 1'b0);
      for (int i = 0; i < PB; i++) tx(8'($urandom), 1'b0, 1'b0);
      wait_ck(20);
      n_chk++; if (n_par !== exp_par) $display("FAIL parity_err got %0d exp %0d", n_par, exp_par); else n_pass++;
      n_chk++; if (acc.size() !== exp_pk.size()) $display("FAIL parity_count got %0d exp %0d", acc.size(), exp_pk.size()); else n_pass++;
      n_chk++; if (acc[$] !== exp_pk[$]) $display("FAIL parity_pkt got %h exp %h", acc[$], exp_pk[$]); else n_pass++;
   endtask
   task automatic test_frame();
      int s = acc.size();
      tx(8'($urandom), 1'b0, 1'b0);
      tx(8'h12, 1'b0, 1'b1);
      wait_ck(20);
      ps2_bit(1'b1);
      exp_frm++;
      wait_ck(20);
      n_chk++; if (n_frm !== exp_frm) $display("FAIL frame_err got %0d exp %0d", n_frm, exp_frm); else n_pass++;
      n_chk++; if (acc.size() !== s) $display("FAIL frame_nopkt got %0d exp %0d", acc.size(), s); else n_pass++;
      n_chk++; if (n_par !== exp_par) $display("FAIL frame_parity got %0d exp %0d", n_par, exp_par); else n_pass++;
   endtask
   task automatic test_timeout();
      int t0, dt;
      tx(8'($urandom), 1'b0, 1'b0);
      tx(8'($urandom), 1'b0, 1'b0);
      t0 = last_fall;
      while (err_timeout !== 1'b1 && cyc - t0 < TO + 600) @(negedge ck);
      dt = cyc - t0;
      n_chk++; if (err_timeout !== 1'b1) $display("FAIL timeout_fired got %b exp 1", err_timeout); else n_pass++;
      n_chk++; if (dt < TO || dt > TO + 15) $display("FAIL timeout_delay got %0d exp %0d..%0d", dt, TO, TO + 15); else n_pass++;
      exp_to++;
      part.delete();
      wait_ck(10);
      n_chk++; if (n_to !== exp_to) $display("FAIL timeout_count got %0d exp %0d", n_to, exp_to); else n_pass++;
      for (int i = 0; i < PB; i++) tx(8'($urandom), 1'b0, 1'b0);
      wait_ck(20);
      n_chk++; if (acc.size() !== exp_pk.size()) $display("FAIL timeout_pkt_count got %0d exp %0d", acc.size(), exp_pk.size()); else n_pass++;
      n_chk++; if (acc[$] !== exp_pk[$]) $display("FAIL timeout_pkt got %h exp %h", acc[$], exp_pk[$]); else n_pass++;
   endtask
   task automatic test_overrun();
      logic [8*PB-1:0] first;
      pkt.packet_ready = 1'b0;
      for (int i = 0; i < PB; i++) tx(8'($urandom), 1'b0, 1'b0);
      first = exp_pk[$];
      n_chk++; if (pkt.packet_valid !== 1'b1) $display("FAIL overrun_valid1 got %b exp 1", pkt.packet_valid); else n_pass++;
      n_chk++; if (pkt.packet_data !== first) $display("FAIL overrun_data1 got %h exp %h", pkt.packet_data, first); else n_pass++;
      for (int i = 0; i < PB; i++) tx(8'($urandom), 1'b0, 1'b0);
      exp_pk.pop_back();
      exp_ovr++;
      n_chk++; if (n_ovr !== exp_ovr) $display("FAIL overrun_err got %0d exp %0d", n_ovr, exp_ovr); else n_pass++;
      n_chk++; if (pkt.packet_data !== first) $display("FAIL overrun_held got %h exp %h", pkt.packet_data, first); else n_pass++;
      @(posedge ck);
      #1 pkt.packet_ready = 1'b1;
      @(negedge ck);
      n_chk++; if (pkt.packet_valid !== 1'b1) $display("FAIL overrun_still_valid got %b exp 1", pkt.packet_valid); else n_pass++;
      @(posedge ck);
      #1;
      n_chk++; if (pkt.packet_valid !== 1'b0) $display("FAIL overrun_drop got %b exp 0", pkt.packet_valid); else n_pass++;
      wait_ck(2);
      n_chk++; if (acc.size() !== exp_pk.size() || acc[$] !== first) $display("FAIL overrun_accept got %h exp %h", acc[$], first); else n_pass++;
   endtask
   task automatic test_glitch();
      int s = acc.size();
      for (int i = 0; i < 6; i++) begin
         ps2_data = 1'(i);
         ps2_clk = 1'b0;
         wait_ck(2 + (i % 2));
         ps2_clk = 1'b1;
         wait_ck(12);
      end
      ps2_data = 1'b1;
      wait_ck(20);
      n_chk++; if (n_frm !== exp_frm) $display("FAIL glitch_frame got %0d exp %0d", n_frm, exp_frm); else n_pass++;
      n_chk++; if (acc.size() !== s) $display("FAIL glitch_nopkt got %0d exp %0d", acc.size(), s); else n_pass++;
      for (int i = 0; i < PB; i++) tx(8'($urandom), 1'b0, 1'b0);
      wait_ck(20);
      n_chk++; if (acc.size() !== exp_pk.size() || acc[$] !== exp_pk[$]) $display("FAIL glitch_pkt got %h exp %h", acc[$], exp_pk[$]); else n_pass++;
   endtask
   task automatic test_back_to_back();
      int s = acc.size();
      int r;
      for (int i = 0; i < 30; i++) begin
         r = int'($urandom_range(0, 9));
         tx(8'($urandom), r == 0, r == 1);
      end
      if (part.size() != 0) begin
         wait_ck(TO + 100);
         exp_to++;
         part.delete();
      end
      wait_ck(20);
      n_chk++; if (acc.size() !== exp_pk.size()) $display("FAIL random_count got %0d exp %0d", acc.size(), exp_pk.size()); else n_pass++;
      for (int k = s; k < exp_pk.size() && k < acc.size(); k++) begin
         n_chk++; if (acc[k] !== exp_pk[k]) $display("FAIL random_pkt%0d got %h exp %h", k, acc[k], exp_pk[k]); else n_pass++;
      end
      n_chk++; if (n_par !== exp_par) $display("FAIL random_parity got %0d exp %0d", n_par, exp_par); else n_pass++;
      n_chk++; if (n_frm !== exp_frm) $display("FAIL random_frame got %0d exp %0d", n_frm, exp_frm); else n_pass++;
      n_chk++; if (n_to !== exp_to) $display("FAIL random_timeout got %0d exp %0d", n_to, exp_to); else n_pass++;
      n_chk++; if (n_ovr !== exp_ovr) $display("FAIL random_overrun got %0d exp %0d", n_ovr, exp_ovr); else n_pass++;
   endtask
`ifdef PS2_PACKET_RX_ERRCNT_EN
   task automatic test_errcnt();
      err_count_clr = 1'b1;
      wait_ck(1);
      err_count_clr = 1'b0;
      wait_ck(1);
      n_chk++; if (err_count !== 8'd0) $display("FAIL errcnt_clr0 got %0d exp 0", err_count); else n_pass++;
      for (int i = 0; i < 3; i++) tx(8'($urandom), 1'b1, 1'b0);
      wait_ck(5);
      n_chk++; if (err_count !== 8'd3) $display("FAIL errcnt_three got %0d exp 3", err_count); else n_pass++;
      err_count_clr = 1'b1;
      wait_ck(1);
      err_count_clr = 1'b0;
      n_chk++; if (err_count !== 8'd0) $display("FAIL errcnt_clr got %0d exp 0", err_count); else n_pass++;
   endtask
`endif
   initial begin
      #2000000;
      $display("FAIL watchdog cycles %0d exp finish", cyc);
      $fatal(1);
   end
   initial begin
      pkt.packet_ready = 1'b1;
      test_reset();
      test_basic();
      test_parity();
      test_frame();
      test_timeout();
      test_overrun();
      test_glitch();
      test_back_to_back();
`ifdef PS2_PACKET_RX_ERRCNT_EN
      test_errcnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
